hazard_ctrl: RTL

Pipeline hazard controller for the RISC-V core. It sits beside the forwarding unit and decides everything forwarding cannot resolve: it stalls on load-use, flushes on taken branches/jumps, and sequences multi-cycle MUL/DIV operations through a start/done handshake. It drives the PC, IF/ID, ID/EX and EX/MEM register enables and flushes, and keeps a stall-cycle counter for performance monitoring.

---
 rtl/hazard_ctrl.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Pipeline hazard controller for the RISC-V core. Resolves what forwarding
// cannot: stalls one cycle on a load-use hazard, squashes IF/ID and ID/EX on a
// taken branch/jump, and sequences multi-cycle MUL/DIV operations through a
// start/done handshake guarded by a watchdog. A saturating counter tracks the
// number of cycles in which the PC was held.
//
// Build option:
//   HAZARD_MULDIV_EN  defined   -> MD_WAIT state, watchdog and MUL/DIV handshake
//                     undefined -> EX_MulDiv/MD_Done ignored; MD_Start,
//                                  ID_EXHold, EX_MEMFlush, MD_Error tied to 0
//
// Parameters:
//   MD_TIMEOUT  max cycles spent in MD_WAIT before the watchdog releases
//   CNT_W       width of Stall_Cnt
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   IF_IDRs1/Rs2        source registers of the instruction in ID
//   IF_IDUsesRs2        ID instruction reads rs2
//   ID_EXMemRead        EX instruction is a load
//   ID_EXRegRd          destination register of the EX instruction
//   EX_BranchTaken      branch/jump resolved taken in EX
//   EX_MulDiv           EX instruction is a MUL/DIV
//   MD_Done             multi-cycle unit result valid (one-cycle pulse)
//   PC_Write            PC load enable
//   IF_IDWrite          IF/ID load enable
//   IF_IDFlush          clear IF/ID to a NOP
//   ID_EXFlush          clear ID/EX to a bubble
//   ID_EXHold           hold ID/EX
//   EX_MEMFlush         insert a bubble into EX/MEM
//   MD_Start            one-cycle start pulse to the MUL/DIV unit
//   MD_Error            sticky watchdog flag
//   Stall_Cnt           saturating count of stalled cycles
//
// States:
//   RUN     | normal flow: branch flush, MUL/DIV launch, load-use bubble
//   MD_WAIT | MUL/DIV in flight: pipeline held until MD_Done or watchdog
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       IF_IDRs1,
  input  logic [4:0]       IF_IDRs2,
  input  logic             IF_IDUsesRs2,
  input  logic             ID_EXMemRead,
  input  logic [4:0]       ID_EXRegRd,
  input  logic             EX_BranchTaken,
  input  logic             EX_MulDiv,
  input  logic             MD_Done,
  output logic             PC_Write,
  output logic             IF_IDWrite,
  output logic             IF_IDFlush,
  output logic             ID_EXFlush,
  output logic             ID_EXHold,
  output logic             EX_MEMFlush,
  output logic             MD_Start,
  output logic             MD_Error,
  output logic [CNT_W-1:0] Stall_Cnt
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    MD_WAIT = 2'b01
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic              lu;
  logic [CNT_W-1:0]  cnt_q;

  // x0 is hardwired to zero, so a load targeting it never creates a hazard.
  assign lu = ID_EXMemRead && (ID_EXRegRd != 5'd0) &&
              ((ID_EXRegRd == IF_IDRs1) ||
               (IF_IDUsesRs2 && (ID_EXRegRd == IF_IDRs2)));

`ifdef HAZARD_MULDIV_EN
  localparam int WD_W = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;

  logic [WD_W-1:0] wd_q;
  logic [WD_W-1:0] wd_d;
  logic            wd_hit;
  logic            err_q;
  logic            err_d;

  assign wd_hit   = (wd_q == WD_W'(MD_TIMEOUT - 1));
  assign MD_Error = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      wd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
    end
  end
`else
  logic unused_md;

  assign unused_md = EX_MulDiv ^ MD_Done;
  assign MD_Error  = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
`ifdef HAZARD_MULDIV_EN
    wd_d        = wd_q;
    err_d       = err_q;
`endif
    PC_Write    = 1'b1;
    IF_IDWrite  = 1'b1;
    IF_IDFlush  = 1'b0;
    ID_EXFlush  = 1'b0;
    ID_EXHold   = 1'b0;
    EX_MEMFlush = 1'b0;
    MD_Start    = 1'b0;

    case (state_q)
      RUN: begin
        // A taken branch discards the ID instruction, so any load-use
        // hazard it carries is moot.
        if (EX_BranchTaken) begin
          IF_IDFlush = 1'b1;
          ID_EXFlush = 1'b1;
`ifdef HAZARD_MULDIV_EN
        end else if (EX_MulDiv) begin
          MD_Start    = 1'b1;
          PC_Write    = 1'b0;
          IF_IDWrite  = 1'b0;
          ID_EXHold   = 1'b1;
          EX_MEMFlush = 1'b1;
          wd_d        = '0;
          state_d     = MD_WAIT;
`endif
        end else if (lu) begin
          PC_Write   = 1'b0;
          IF_IDWrite = 1'b0;
          ID_EXFlush = 1'b1;
        end
      end
`ifdef HAZARD_MULDIV_EN
      MD_WAIT: begin
        // The release cycle uses default outputs so the result moves into
        // EX/MEM; EX_MulDiv is still high here but only RUN looks at it.
        if (MD_Done) begin
          state_d = RUN;
        end else if (wd_hit) begin
          err_d   = 1'b1;
          state_d = RUN;
        end else begin
          PC_Write    = 1'b0;
          IF_IDWrite  = 1'b0;
          ID_EXHold   = 1'b1;
          EX_MEMFlush = 1'b1;
          wd_d        = wd_q + 1'b1;
        end
      end
`endif
      default: begin
        state_d = RUN;
      end
    endcase

    // Reset squashes the front of the pipeline and freezes the PC.
    if (rst) begin
      PC_Write    = 1'b0;
      IF_IDWrite  = 1'b0;
      IF_IDFlush  = 1'b1;
      ID_EXFlush  = 1'b1;
      ID_EXHold   = 1'b0;
      EX_MEMFlush = 1'b0;
      MD_Start    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (!PC_Write && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign Stall_Cnt = cnt_q;

endmodule
